request_collector: RTL and testbench
====================================

Name: request_collector

Overview:
- Upstream feeder for the two-client request arbiter.
- Captures single-cycle request pulses from two clients and keeps a saturating pending count per client.
- Presents level requests R0/R1 to the arbiter, retires one pending request on each new grant (G0/G1 rising edge), then enforces a fixed service window before that client re-requests.
- Reports pending counts plus sticky overflow and spurious-grant flags.

Parameters:
- CNT_W, 3: width of each pending counter.
- MAX_PEND, 7: saturation limit; must be ≤ 2^CNT_W − 1 and ≥ 1.
- SERVICE_CYCLES, 4: cycles R_i is held low after a grant is consumed; ≥ 1.
- SVC_W, 3: service timer width; must hold SERVICE_CYCLES.

Ports:
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-low; clears all state.
- req_pulse0, input, 1: client 0 request event, one count per high cycle.
- req_pulse1, input, 1: client 1 request event.
- G0, input, 1: grant to client 0 from arbiter.
- G1, input, 1: grant to client 1 from arbiter.
- clr_flags, input, 1: synchronous clear of all sticky flags.
- R0, output, 1: level request to arbiter, client 0.
- R1, output, 1: level request to arbiter, client 1.
- pend_cnt0, output, CNT_W: client 0 pending count.
- pend_cnt1, output, CNT_W: client 1 pending count.
- ovf0, output, 1: sticky; client 0 pulse arrived while count = MAX_PEND.
- ovf1, output, 1: sticky; same for client 1.
- spur0, output, 1: sticky; G0 rose while R0 low.
- spur1, output, 1: sticky; same for client 1.

Behaviour:
- Reset (async assert, reset=0): all counts 0, lane state IDLE, timers 0, grant-delay regs 0, all flags 0. R0=R1=0, pend_cnt*=0.
- All outputs decode from registers only; there is no combinational path from any input to any output.
- Two lanes, fully independent, identical. Lane i state machine:
  - IDLE: cnt=0, R_i=0. Goes to REQ when cnt becomes >0.
  - REQ: cnt>0, R_i=1.
  - SERVICE: timer>0, R_i=0 regardless of cnt.
- Grant edge: gedge_i = G_i & ~g_d_i, where g_d_i is G_i registered every cycle.
- Consume: gedge_i while in REQ.
  - cnt decrements at that edge.
  - timer loads SERVICE_CYCLES; state goes to SERVICE.
  - R_i is low from the next cycle on.
- SERVICE:
  - Timer decrements each cycle.
  - When timer reaches 0, state goes to REQ if cnt>0, else IDLE.
  - R_i is therefore low for exactly SERVICE_CYCLES cycles.
- Latency:
  - req_pulse_i high in cycle t (lane IDLE): cnt=1 and R_i=1 in cycle t+1.
  - Consume in cycle t: R_i=0 in cycles t+1 .. t+SERVICE_CYCLES; R_i=1 again at t+SERVICE_CYCLES+1 if cnt>0.
- Increment: req_pulse_i in any state adds 1, including SERVICE.
- Pulse and consume in the same cycle: cnt unchanged; SERVICE is still entered.
- Pulse at cnt=MAX_PEND: cnt holds, ovf_i set. If a consume happens the same cycle, net is unchanged and ovf_i is NOT set.
- Spurious grant: gedge_i while state ≠ REQ. No decrement, no timer load, spur_i set.
- G_i held high over many cycles consumes only once; a new rise is needed to consume again.
- clr_flags clears all four flags next edge. An event in the same cycle as clr_flags wins: the flag is set.
- Counter never wraps below 0 or above MAX_PEND.
- Reset asserted mid-SERVICE or mid-REQ: immediate clear; R drops asynchronously.

Decomposition:
- Shared package request_collector_pkg:
  - lane state enum: IDLE=2'b00, REQ=2'b01, SERVICE=2'b10.
  - default CNT_W/MAX_PEND/SERVICE_CYCLES constants.
  - elaboration checks on parameter legality.
- One sub-module, request_collector_lane: counter, timer, grant-edge reg, state machine and the two flags for one client. Top instantiates it twice and shares clr_flags.
- Expected size ~200 lines total.

Test Plan:
- Reset then single req_pulse0 at cycle 5 → R0=1 and pend_cnt0=1 at cycle 6. G0 rises at cycle 7 → pend_cnt0=0, R0=0 cycles 8–11, state IDLE, R0 stays 0.
- 3 pulses on client 1 back-to-back (cycles 2–4) → pend_cnt1=3. Grant edges at cycles 6, 12, 18 → counts 2, 1, 0. R1 low exactly 4 cycles after each consume.
- 9 pulses to client 0 with no grants → pend_cnt0 saturates at 7, ovf0=1 after the 8th pulse. clr_flags pulse → ovf0=0, pend_cnt0 still 7.
- pend_cnt0=2 in REQ, req_pulse0 and G0 rise in the same cycle → pend_cnt0 stays 2, lane enters SERVICE, ovf0 stays 0.
- G1 rising with pend_cnt1=0 → spur1=1, counts unchanged. G0 held high for 10 cycles with pend_cnt0=3 → exactly one decrement (to 2).
- reset driven low mid-SERVICE with pend_cnt0=4, ovf1=1 → all outputs 0 immediately. After release, the first pulse gives R=1 one cycle later.

Source files
------------

// File: rtl/request_collector_pkg.sv
// Shared types and defaults for the two-lane request collector.
// Holds the lane state encoding and the parameter legality check.
package request_collector_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } lane_state_e;

  localparam int unsigned DEF_CNT_W          = 3;
  localparam int unsigned DEF_MAX_PEND       = 7;
  localparam int unsigned DEF_SERVICE_CYCLES = 4;
  localparam int unsigned DEF_SVC_W          = 3;

  function automatic bit params_ok(input int unsigned cnt_w,
                                   input int unsigned max_pend,
                                   input int unsigned svc_cycles,
                                   input int unsigned svc_w);
    return (max_pend >= 1) && (max_pend <= (1 << cnt_w) - 1) &&
           (svc_cycles >= 1) && (svc_cycles <= (1 << svc_w) - 1);
  endfunction

endpackage

// File: rtl/request_collector_lane.sv
// One client lane: saturating pending counter, grant-edge detect,
// service-window timer, IDLE/REQ/SERVICE state machine and sticky flags.
module request_collector_lane
  import request_collector_pkg::*;
#(
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned MAX_PEND       = DEF_MAX_PEND,
  parameter int unsigned SERVICE_CYCLES = DEF_SERVICE_CYCLES,
  parameter int unsigned SVC_W          = DEF_SVC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_pulse,
  input  logic             i_grant,
  input  logic             i_clr_flags,
  output logic             o_req,
  output logic [CNT_W-1:0] o_pend_cnt,
  output logic             o_ovf,
  output logic             o_spur
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_PEND);
  localparam logic [SVC_W-1:0] LP_SVC = SVC_W'(SERVICE_CYCLES);

  lane_state_e      r_state;
  lane_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [SVC_W-1:0] r_timer;
  logic [SVC_W-1:0] w_timer_nxt;
  logic             r_g_d;
  logic             r_ovf;
  logic             r_spur;
  logic             w_gedge;
  logic             w_consume;
  logic             w_spur_ev;
  logic             w_sat;
  logic             w_ovf_ev;

  always_comb begin
    w_gedge   = i_grant & ~r_g_d;
    w_consume = w_gedge & (r_state == REQ);
    w_spur_ev = w_gedge & (r_state != REQ);
    w_sat     = (r_cnt == LP_MAX);
    // A consume in the same cycle frees the slot, so a pulse at MAX is not an overflow.
    w_ovf_ev  = i_req_pulse & w_sat & ~w_consume;

    w_cnt_nxt = r_cnt;
    if (i_req_pulse && !w_consume && !w_sat) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else if (w_consume && !i_req_pulse && (r_cnt != '0)) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end

    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      IDLE: begin
        if (w_cnt_nxt != '0) w_state_nxt = REQ;
      end
      REQ: begin
        if (w_consume) begin
          w_state_nxt = SERVICE;
          w_timer_nxt = LP_SVC;
        end
      end
      SERVICE: begin
        // Exit on the last count so R stays low for exactly SERVICE_CYCLES cycles.
        if (r_timer <= SVC_W'(1)) begin
          w_timer_nxt = '0;
          w_state_nxt = (w_cnt_nxt != '0) ? REQ : IDLE;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_timer <= '0;
      r_g_d   <= 1'b0;
      r_ovf   <= 1'b0;
      r_spur  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_timer <= w_timer_nxt;
      r_g_d   <= i_grant;
      r_ovf   <= w_ovf_ev | (r_ovf & ~i_clr_flags);
      r_spur  <= w_spur_ev | (r_spur & ~i_clr_flags);
    end
  end

  always_comb begin
    o_req      = (r_state == REQ);
    o_pend_cnt = r_cnt;
    o_ovf      = r_ovf;
    o_spur     = r_spur;
  end

endmodule

// File: rtl/request_collector.sv
// Two-client request collector feeding the request arbiter.
// Two identical independent lanes share the clock, reset and flag clear.
module request_collector
  import request_collector_pkg::*;
#(
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned MAX_PEND       = DEF_MAX_PEND,
  parameter int unsigned SERVICE_CYCLES = DEF_SERVICE_CYCLES,
  parameter int unsigned SVC_W          = DEF_SVC_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_pulse0,
  input  logic             req_pulse1,
  input  logic             G0,
  input  logic             G1,
  input  logic             clr_flags,
  output logic             R0,
  output logic             R1,
  output logic [CNT_W-1:0] pend_cnt0,
  output logic [CNT_W-1:0] pend_cnt1,
  output logic             ovf0,
  output logic             ovf1,
  output logic             spur0,
  output logic             spur1
);

  if (!params_ok(CNT_W, MAX_PEND, SERVICE_CYCLES, SVC_W)) begin : g_bad_params
    $error("request_collector: illegal CNT_W/MAX_PEND/SERVICE_CYCLES/SVC_W combination");
  end

  request_collector_lane #(
    .CNT_W         (CNT_W),
    .MAX_PEND      (MAX_PEND),
    .SERVICE_CYCLES(SERVICE_CYCLES),
    .SVC_W         (SVC_W)
  ) u_lane0 (
    .clk        (clock),
    .rst_n      (reset),
    .i_req_pulse(req_pulse0),
    .i_grant    (G0),
    .i_clr_flags(clr_flags),
    .o_req      (R0),
    .o_pend_cnt (pend_cnt0),
    .o_ovf      (ovf0),
    .o_spur     (spur0)
  );

  request_collector_lane #(
    .CNT_W         (CNT_W),
    .MAX_PEND      (MAX_PEND),
    .SERVICE_CYCLES(SERVICE_CYCLES),
    .SVC_W         (SVC_W)
  ) u_lane1 (
    .clk        (clock),
    .rst_n      (reset),
    .i_req_pulse(req_pulse1),
    .i_grant    (G1),
    .i_clr_flags(clr_flags),
    .o_req      (R1),
    .o_pend_cnt (pend_cnt1),
    .o_ovf      (ovf1),
    .o_spur     (spur1)
  );

endmodule

// File: tb/tb_request_collector.sv
// Directed bench for request_collector: a cycle-by-cycle vector table
// followed by hand-written saturation, held-grant and async-reset sequences.
module tb_request_collector;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_pulse0, req_pulse1, G0, G1, clr_flags;
  logic       R0, R1;
  logic [2:0] pend_cnt0, pend_cnt1;
  logic       ovf0, ovf1, spur0, spur1;

  request_collector #(
    .CNT_W         (3),
    .MAX_PEND      (7),
    .SERVICE_CYCLES(4),
    .SVC_W         (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_pulse0(req_pulse0),
    .req_pulse1(req_pulse1),
    .G0        (G0),
    .G1        (G1),
    .clr_flags (clr_flags),
    .R0        (R0),
    .R1        (R1),
    .pend_cnt0 (pend_cnt0),
    .pend_cnt1 (pend_cnt1),
    .ovf0      (ovf0),
    .ovf1      (ovf1),
    .spur0     (spur0),
    .spur1     (spur1)
  );

  always #5 clock = ~clock;

  // in = {pulse0, pulse1, G0, G1, clr}; f = {ovf0, ovf1, spur0, spur1}
  typedef struct {
    logic [4:0] in;
    logic [1:0] r;
    logic [2:0] c0;
    logic [2:0] c1;
    logic [3:0] f;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t v(input logic [4:0] in, input logic [1:0] r,
                             input int c0, input int c1, input logic [3:0] f);
    vec_t x;
    x.in = in; x.r = r; x.c0 = 3'(c0); x.c1 = 3'(c1); x.f = f;
    return x;
  endfunction

  task automatic drive(input logic [4:0] in);
    {req_pulse0, req_pulse1, G0, G1, clr_flags} = in;
  endtask

  task automatic step(input logic [4:0] in);
    drive(in);
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] r, input int c0,
                       input int c1, input logic [3:0] f);
    logic [11:0] got, exp;
    got = {R0, R1, pend_cnt0, pend_cnt1, ovf0, ovf1, spur0, spur1};
    exp = {r, 3'(c0), 3'(c1), f};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {R0R1,c0,c1,o0o1s0s1}=%b_%0d_%0d_%b required %b_%0d_%0d_%b",
               name, got[11:10], got[9:7], got[6:4], got[3:0],
               exp[11:10], exp[9:7], exp[6:4], exp[3:0]);
    end
  endtask

  initial begin
    // Single pulse on lane 0, consume, 4-cycle service window back to IDLE.
    tbl.push_back(v(5'b00000, 2'b00, 0, 0, 4'b0000));
    tbl.push_back(v(5'b10000, 2'b10, 1, 0, 4'b0000));
    tbl.push_back(v(5'b00000, 2'b10, 1, 0, 4'b0000));
    tbl.push_back(v(5'b00100, 2'b00, 0, 0, 4'b0000));
    tbl.push_back(v(5'b00000, 2'b00, 0, 0, 4'b0000));
    tbl.push_back(v(5'b00000, 2'b00, 0, 0, 4'b0000));
    tbl.push_back(v(5'b00000, 2'b00, 0, 0, 4'b0000));
    tbl.push_back(v(5'b00000, 2'b00, 0, 0, 4'b0000));
    // Lane 1: three pulses, consume with held grant, return to REQ.
    tbl.push_back(v(5'b01000, 2'b01, 0, 1, 4'b0000));
    tbl.push_back(v(5'b01000, 2'b01, 0, 2, 4'b0000));
    tbl.push_back(v(5'b01000, 2'b01, 0, 3, 4'b0000));
    tbl.push_back(v(5'b00010, 2'b00, 0, 2, 4'b0000));
    tbl.push_back(v(5'b00010, 2'b00, 0, 2, 4'b0000));
    tbl.push_back(v(5'b00000, 2'b00, 0, 2, 4'b0000));
    tbl.push_back(v(5'b00000, 2'b00, 0, 2, 4'b0000));
    tbl.push_back(v(5'b00000, 2'b01, 0, 2, 4'b0000));
    // Consume, then a pulse arrives during SERVICE.
    tbl.push_back(v(5'b00010, 2'b00, 0, 1, 4'b0000));
    tbl.push_back(v(5'b01000, 2'b00, 0, 2, 4'b0000));
    tbl.push_back(v(5'b00000, 2'b00, 0, 2, 4'b0000));
    tbl.push_back(v(5'b00000, 2'b00, 0, 2, 4'b0000));
    tbl.push_back(v(5'b00000, 2'b01, 0, 2, 4'b0000));
    // Pulse and consume in the same cycle: count unchanged, SERVICE entered.
    tbl.push_back(v(5'b01010, 2'b00, 0, 2, 4'b0000));
    tbl.push_back(v(5'b00000, 2'b00, 0, 2, 4'b0000));
    tbl.push_back(v(5'b00000, 2'b00, 0, 2, 4'b0000));
    tbl.push_back(v(5'b00000, 2'b00, 0, 2, 4'b0000));
    tbl.push_back(v(5'b00000, 2'b01, 0, 2, 4'b0000));
    // Spurious grants in IDLE and SERVICE, clear, clear racing an event.
    tbl.push_back(v(5'b00100, 2'b01, 0, 2, 4'b0010));
    tbl.push_back(v(5'b00000, 2'b01, 0, 2, 4'b0010));
    tbl.push_back(v(5'b00010, 2'b00, 0, 1, 4'b0010));
    tbl.push_back(v(5'b00000, 2'b00, 0, 1, 4'b0010));
    tbl.push_back(v(5'b00010, 2'b00, 0, 1, 4'b0011));
    tbl.push_back(v(5'b00001, 2'b00, 0, 1, 4'b0000));
    tbl.push_back(v(5'b00101, 2'b01, 0, 1, 4'b0010));
    tbl.push_back(v(5'b00000, 2'b01, 0, 1, 4'b0010));

    reset = 1'b0;
    drive(5'b00000);
    #12;
    check("reset_state", 2'b00, 0, 0, 4'b0000);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    foreach (tbl[i]) begin
      step(tbl[i].in);
      check($sformatf("vec%0d", i), tbl[i].r, tbl[i].c0, tbl[i].c1, tbl[i].f);
    end

    // Saturation on lane 0: nine pulses, overflow only from the 8th.
    for (int k = 1; k <= 9; k++) begin
      step(5'b10000);
      check($sformatf("sat_pulse%0d", k), 2'b11, (k < 7) ? k : 7, 1,
            {(k >= 8), 1'b0, 1'b1, 1'b0});
    end
    step(5'b00001);
    check("sat_clr", 2'b11, 7, 1, 4'b0000);

    // Pulse plus consume at MAX: no overflow, count holds.
    step(5'b10100);
    check("sat_pulse_consume", 2'b01, 7, 1, 4'b0000);

    // G0 kept high: the window expires but no second consume occurs.
    for (int k = 1; k <= 9; k++) begin
      step(5'b00100);
      check($sformatf("g0_held%0d", k), {(k >= 4), 1'b1}, 7, 1, 4'b0000);
    end
    step(5'b00000);
    check("g0_release", 2'b11, 7, 1, 4'b0000);
    step(5'b00100);
    check("g0_new_rise", 2'b01, 6, 1, 4'b0000);

    // Drive lane 1 to overflow while lane 0 finishes its window.
    for (int k = 1; k <= 7; k++) begin
      step(5'b01000);
      check($sformatf("ovf1_pulse%0d", k), {(k >= 4), 1'b1}, 6,
            (k < 6) ? k + 1 : 7, {1'b0, (k >= 7), 2'b00});
    end
    step(5'b00100);
    check("pre_reset_consume", 2'b01, 5, 7, 4'b0100);
    step(5'b00000);
    check("pre_reset_service", 2'b01, 5, 7, 4'b0100);

    // Asynchronous reset mid-SERVICE, between clock edges.
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 2'b00, 0, 0, 4'b0000);
    @(posedge clock);
    #1;
    check("reset_held", 2'b00, 0, 0, 4'b0000);
    @(negedge clock);
    reset = 1'b1;
    step(5'b10000);
    check("post_reset_pulse", 2'b10, 1, 0, 4'b0000);
    step(5'b00000);
    check("post_reset_hold", 2'b10, 1, 0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
